axi_stream_pkt_arbiter: RTL and testbench



---
 rtl/axi_stream_pkt_arbiter.sv | 139 +++++++++++++
 tb/tb_axi_stream_pkt_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_pkt_arbiter.sv
// Packet-granular round-robin N:1 AXI Stream arbiter with zero-latency passthrough.
// Define AXI_STREAM_PKT_ARB_STATS_EN to add per-source completed-packet counters (pkt_cnt_o).

package axi_stream_pkt_arbiter_pkg;
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  keep;
        logic        last;
        logic [3:0]  id;
        logic [3:0]  dest;
        logic [3:0]  user;
    } axis_chan_t;

    typedef struct packed {
        axis_chan_t t;
        logic       tvalid;
    } axis_req_t;

    typedef struct packed {
        logic tready;
    } axis_rsp_t;
endpackage

module axi_stream_pkt_arbiter #(
    parameter int unsigned NumInp = 2,
    parameter type axi_stream_req_t = axi_stream_pkt_arbiter_pkg::axis_req_t,
    parameter type axi_stream_rsp_t = axi_stream_pkt_arbiter_pkg::axis_rsp_t,
    parameter int unsigned IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1,
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  axi_stream_req_t     in_req_i [NumInp],
    output axi_stream_rsp_t     in_rsp_o [NumInp],
    output axi_stream_req_t     out_req_o,
    input  axi_stream_rsp_t     out_rsp_i,
`ifdef AXI_STREAM_PKT_ARB_STATS_EN
    output logic [CntWidth-1:0] pkt_cnt_o [NumInp],
`endif
    output logic [IdxWidth-1:0] idx_o,
    output logic                locked_o
);

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StLocked = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxWidth-1:0] gnt_q, gnt_d;
    logic [IdxWidth-1:0] gnt_c, sel;
    logic [31:0]         pos;
    logic                any_valid, conn, hs_last;

    function automatic logic [IdxWidth-1:0] next_idx(input logic [IdxWidth-1:0] i);
        if (32'(i) == NumInp - 1) return '0;
        return i + 1'b1;
    endfunction

    // First valid source at or after rr_ptr_q, wrapping modulo NumInp.
    always_comb begin
        gnt_c     = rr_ptr_q;
        any_valid = 1'b0;
        pos       = '0;
        for (int unsigned k = 0; k < NumInp; k++) begin
            pos = (32'(rr_ptr_q) + k) % NumInp;
            if (!any_valid && in_req_i[pos[IdxWidth-1:0]].tvalid) begin
                gnt_c     = pos[IdxWidth-1:0];
                any_valid = 1'b1;
            end
        end
    end

    // Handshake: a beat transfers when out tvalid && out tready; tvalid of the selected
    // source is never gated by tready, and a presented beat keeps its owner until accepted.
    always_comb begin
        sel       = (state_q == StLocked) ? gnt_q : gnt_c;
        conn      = rst_ni && ((state_q == StLocked) || any_valid);
        out_req_o = '0;
        for (int unsigned i = 0; i < NumInp; i++) in_rsp_o[i] = '0;
        if (conn) begin
            out_req_o     = in_req_i[sel];
            in_rsp_o[sel] = out_rsp_i;
        end
    end

    assign hs_last  = out_req_o.tvalid && out_rsp_i.tready && out_req_o.t.last;
    assign idx_o    = conn ? sel : gnt_q;
    assign locked_o = (state_q == StLocked);

    // Idle locks on any presented beat that does not complete a packet, handshake or not.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        if (state_q == StIdle) begin
            if (out_req_o.tvalid) begin
                gnt_d = gnt_c;
                if (hs_last) rr_ptr_d = next_idx(gnt_c);
                else         state_d  = StLocked;
            end
        end else if (hs_last) begin
            state_d  = StIdle;
            rr_ptr_d = next_idx(gnt_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
        end
    end

`ifdef AXI_STREAM_PKT_ARB_STATS_EN
    logic [CntWidth-1:0] cnt_q [NumInp];
    logic [CntWidth-1:0] cnt_d [NumInp];

    always_comb begin
        for (int unsigned i = 0; i < NumInp; i++) cnt_d[i] = cnt_q[i];
        if (hs_last) cnt_d[sel] = cnt_q[sel] + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < NumInp; i++) begin
            if (!rst_ni) cnt_q[i] <= '0;
            else         cnt_q[i] <= cnt_d[i];
        end
    end

    assign pkt_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_axi_stream_pkt_arbiter.sv
// Random-stimulus bench for axi_stream_pkt_arbiter (4 sources) with a packet-level
// round-robin reference model and per-source expected-beat queues.

module tb_axi_stream_pkt_arbiter;
    import axi_stream_pkt_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TW = $bits(axis_chan_t);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    axis_req_t       in_req [N];
    axis_rsp_t       in_rsp [N];
    axis_req_t       out_req;
    axis_rsp_t       out_rsp;
    logic [IW-1:0]   idx;
    logic            locked;
`ifdef AXI_STREAM_PKT_ARB_STATS_EN
    logic [15:0]     pkt_cnt [N];
    int              m_cnt [N];
`endif

    always #5 clk = ~clk;

    axi_stream_pkt_arbiter #(
        .NumInp           (N),
        .axi_stream_req_t (axis_req_t),
        .axi_stream_rsp_t (axis_rsp_t)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .in_req_i  (in_req),
        .in_rsp_o  (in_rsp),
        .out_req_o (out_req),
        .out_rsp_i (out_rsp),
`ifdef AXI_STREAM_PKT_ARB_STATS_EN
        .pkt_cnt_o (pkt_cnt),
`endif
        .idx_o     (idx),
        .locked_o  (locked)
    );

    // Scoreboard: beats each source has issued but the output has not yet accepted.
    logic [TW-1:0] exp_q [N][$];

    logic       src_valid [N];
    axis_chan_t src_beat [N];
    int         src_left [N];
    logic       hs [N];

    // Packet-level reference: owner of the output, next priority, last granted source.
    logic m_owned;
    int   m_owner, m_ptr, m_last;

    int checks = 0, errors = 0, n_hs = 0;
    int vprob, rprob, maxlen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owned = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_last  = 0;
`ifdef AXI_STREAM_PKT_ARB_STATS_EN
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
`endif
    endtask

    task automatic drive_sources();
        for (int i = 0; i < N; i++) begin
            if (hs[i]) src_valid[i] = 1'b0;
            if (!src_valid[i] && $urandom_range(0, 99) < vprob) begin
                if (src_left[i] == 0) src_left[i] = $urandom_range(1, maxlen);
                src_beat[i].data = $urandom;
                src_beat[i].strb = 4'($urandom);
                src_beat[i].keep = 4'($urandom);
                src_beat[i].id   = 4'($urandom);
                src_beat[i].dest = 4'($urandom);
                src_beat[i].user = 4'($urandom);
                src_beat[i].last = (src_left[i] == 1);
                src_left[i]--;
                src_valid[i] = 1'b1;
                exp_q[i].push_back(src_beat[i]);
            end
            in_req[i].tvalid = src_valid[i];
            in_req[i].t      = src_valid[i] ? src_beat[i] : axis_chan_t'({$urandom, $urandom});
        end
        out_rsp.tready = ($urandom_range(0, 99) < rprob);
    endtask

    task automatic check_cycle();
        int   sel, j;
        logic conn, exp_v, er;
        for (int i = 0; i < N; i++) hs[i] = 1'b0;
        if (!rst_n) begin
            check("rst_out_tvalid", 64'(out_req.tvalid), 64'd0);
            for (int i = 0; i < N; i++) check("rst_in_tready", 64'(in_rsp[i].tready), 64'd0);
            model_reset();
            return;
        end
        conn = 1'b0;
        sel  = m_last;
        if (m_owned) begin
            conn = 1'b1;
            sel  = m_owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (!conn && src_valid[j]) begin
                    conn = 1'b1;
                    sel  = j;
                end
            end
        end
        exp_v = conn && src_valid[sel];
        check("out_tvalid", 64'(out_req.tvalid), 64'(exp_v));
        check("locked", 64'(locked), 64'(m_owned));
        check("idx", 64'(idx), 64'(conn ? sel : m_last));
        for (int i = 0; i < N; i++) begin
            er = conn && (i == sel) && out_rsp.tready;
            check("in_tready", 64'(in_rsp[i].tready), 64'(er));
            hs[i] = er && src_valid[i];
        end
`ifdef AXI_STREAM_PKT_ARB_STATS_EN
        for (int i = 0; i < N; i++) check("pkt_cnt", 64'(pkt_cnt[i]), 64'(16'(m_cnt[i])));
`endif
        if (exp_v) begin
            if (exp_q[sel].size() == 0) begin
                check("scoreboard_nonempty", 64'd0, 64'd1);
            end else begin
                check("out_payload", 64'(out_req.t), 64'(exp_q[sel][0]));
                if (out_rsp.tready) begin
                    void'(exp_q[sel].pop_front());
                    n_hs++;
                end
            end
            m_last = sel;
            if (out_rsp.tready && src_beat[sel].last) begin
                m_owned = 1'b0;
                m_ptr   = (sel + 1) % N;
`ifdef AXI_STREAM_PKT_ARB_STATS_EN
                m_cnt[sel] = m_cnt[sel] + 1;
`endif
            end else begin
                m_owned = 1'b1;
                m_owner = sel;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            src_valid[i] = 1'b0;
            src_beat[i]  = '0;
            src_left[i]  = 0;
            hs[i]        = 1'b0;
            in_req[i]    = '0;
        end
        out_rsp = '0;
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            rst_n = !(cyc < 3 || cyc == 900 || cyc == 1700 || cyc == 2400);
            if (cyc < 300) begin
                vprob = 100; rprob = 100; maxlen = 1;
            end else if (cyc < 600) begin
                vprob = 100; rprob = 100; maxlen = 3;
            end else if (cyc < 2000) begin
                vprob = 50; rprob = 60; maxlen = 4;
            end else begin
                vprob = 30; rprob = 20; maxlen = 4;
            end
            drive_sources();
            @(negedge clk);
            check_cycle();
        end
        check("handshakes_seen", 64'(n_hs > 500), 64'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
